// File: rtl/result_collector_pkg.sv
// Shared defaults, PE indexing helper and FSM encoding for the result collector.
// Combinational helpers only; no state, no latency, no flow control.
package result_collector_pkg;

  localparam int SIZE_DEF = 8;
  localparam int DW_DEF   = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;

  function automatic int idx(input int r, input int c, input int size = SIZE_DEF);
    return r * size + c;
  endfunction

endpackage

// File: rtl/result_collector_row_slot.sv
// One row of shadow registers with capture mask; captures on rise, 1-cycle to full.
// A pop (i_clr) frees the row before same-cycle captures; a rise on a held bit is reported as a drop.
module collector_row_slot import result_collector_pkg::*; #(
  parameter int SIZE = SIZE_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SIZE-1:0]    i_rise,
  input  logic [SIZE*DW-1:0] i_data,
  input  logic               i_clr,
  output logic [SIZE*DW-1:0] o_data,
  output logic               o_full_nxt,
  output logic               o_any_nxt,
  output logic               o_drop
);

  logic [SIZE-1:0]    r_mask;
  logic [SIZE*DW-1:0] r_shadow;
  logic [SIZE-1:0]    w_mask_base;
  logic [SIZE-1:0]    w_cap;
  logic [SIZE-1:0]    w_mask_nxt;

  // Clearing first lets a next-tile rise land in the slot being popped.
  assign w_mask_base = i_clr ? '0 : r_mask;
  assign w_cap       = i_rise & ~w_mask_base;
  assign w_mask_nxt  = w_mask_base | w_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask   <= '0;
      r_shadow <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      for (int c = 0; c < SIZE; c++) begin
        if (w_cap[c]) r_shadow[c*DW +: DW] <= i_data[c*DW +: DW];
      end
    end
  end

  assign o_data     = r_shadow;
  assign o_full_nxt = &w_mask_nxt;
  assign o_any_nxt  = |w_mask_nxt;
  assign o_drop     = |(i_rise & w_mask_base);

endmodule

// File: rtl/result_collector.sv
// Snapshots PE results on finish rises and drains complete rows in order; row valid 1 cycle after its last rise.
// Beats hold stable under out_ready low; captures into still-held slots are dropped and flagged on overrun.
module result_collector import result_collector_pkg::*; #(
  parameter int SIZE = SIZE_DEF,
  parameter int DW   = DW_DEF,
  parameter int RW   = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SIZE*SIZE-1:0]    finish,
  input  logic [SIZE*SIZE*DW-1:0] pe_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE*DW-1:0]      out_data,
  output logic [RW-1:0]           out_row,
  output logic                    out_last,
  output logic                    tile_done,
  output logic                    overrun
);

  logic [SIZE*SIZE-1:0] r_finish_q;
  logic [SIZE*SIZE-1:0] w_rise;
  logic [RW-1:0]        r_row_ptr;
  logic [RW-1:0]        w_ptr_nxt;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_tile_done;
  logic                 r_overrun;
  logic                 w_xfer;
  logic                 w_last;
  logic [SIZE-1:0]      w_clr;
  logic [SIZE-1:0]      w_full_nxt;
  logic [SIZE-1:0]      w_any_nxt;
  logic [SIZE-1:0]      w_drop;
  logic [SIZE*DW-1:0]   w_row_data [SIZE];

  assign w_rise    = finish & ~r_finish_q;
  assign w_last    = (r_row_ptr == RW'(SIZE - 1));
  assign w_xfer    = out_valid & out_ready;
  assign w_ptr_nxt = !w_xfer ? r_row_ptr : (w_last ? '0 : r_row_ptr + RW'(1));

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    assign w_clr[r] = w_xfer & (r_row_ptr == RW'(r));

    collector_row_slot #(.SIZE(SIZE), .DW(DW)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rise     (w_rise[idx(r, 0, SIZE) +: SIZE]),
      .i_data     (pe_result[idx(r, 0, SIZE)*DW +: SIZE*DW]),
      .i_clr      (w_clr[r]),
      .o_data     (w_row_data[r]),
      .o_full_nxt (w_full_nxt[r]),
      .o_any_nxt  (w_any_nxt[r]),
      .o_drop     (w_drop[r])
    );
  end

  // State is derived from the post-update mask so SEND always means full[row_ptr].
  always_comb begin
    w_state_nxt = ST_COLLECT;
    if (!(|w_any_nxt))             w_state_nxt = ST_IDLE;
    else if (w_full_nxt[w_ptr_nxt]) w_state_nxt = ST_SEND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_finish_q  <= '0;
      r_row_ptr   <= '0;
      r_state     <= ST_IDLE;
      r_tile_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_finish_q  <= finish;
      r_row_ptr   <= w_ptr_nxt;
      r_state     <= w_state_nxt;
      r_tile_done <= w_xfer & w_last;
      if (|w_drop) r_overrun <= 1'b1;
    end
  end

  assign out_valid = (r_state == ST_SEND);
  assign out_data  = w_row_data[r_row_ptr];
  assign out_row   = r_row_ptr;
  assign out_last  = out_valid & w_last;
  assign tile_done = r_tile_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench: directed wavefront scenarios plus randomized overlapping tiles vs a row/PE array model.
module tb_result_collector;

  localparam int SIZE = 8;
  localparam int DW   = 16;
  localparam int N    = SIZE * SIZE;
  localparam int RW   = 3;
  localparam int W    = SIZE * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    finish = '0;
  logic [N*DW-1:0] pe_result;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic [RW-1:0]   out_row;
  logic            out_last;
  logic            tile_done;
  logic            overrun;

  result_collector #(.SIZE(SIZE), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .finish    (finish),
    .pe_result (pe_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .tile_done (tile_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  logic [DW-1:0] pe_val [N];
  always_comb begin
    pe_result = '0;
    for (int i = 0; i < N; i++) pe_result[i*DW +: DW] = pe_val[i];
  end

  // Reference model: per-PE captured flag/value, next row to emit, sticky drop flag.
  logic          m_mask   [N];
  logic [DW-1:0] m_shadow [N];
  logic          m_prev   [N];
  int            m_ptr;
  logic          m_ovr;
  logic          m_td_pend;

  logic          exp_vld, exp_td, exp_ovr;
  int            exp_row;
  logic [W-1:0]  exp_dat;
  logic          chk_en = 1'b0;

  typedef struct packed {
    logic [W-1:0]  dat;
    logic [RW-1:0] row;
    logic          last;
  } beat_t;
  beat_t exp_q [$];

  int t_start [16];
  int t_base  [16];
  int t_dly   [16][N];
  int ntiles;
  int rdy_lo, rdy_hi;
  bit rdy_rand;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  function automatic logic row_full(input int r);
    logic f;
    f = 1'b1;
    for (int c = 0; c < SIZE; c++) f = f & m_mask[r*SIZE + c];
    return f;
  endfunction

  function automatic void add_wave(input int t0, input int base);
    t_start[ntiles] = t0;
    t_base[ntiles]  = base;
    for (int i = 0; i < N; i++) t_dly[ntiles][i] = i / SIZE + i % SIZE;
    ntiles++;
  endfunction

  function automatic void add_rand_tile(input int t0, input int base);
    t_start[ntiles] = t0;
    t_base[ntiles]  = base;
    for (int i = 0; i < N; i++) t_dly[ntiles][i] = $urandom_range(0, 12);
    ntiles++;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mask[i]   = 1'b0;
      m_shadow[i] = '0;
      m_prev[i]   = 1'b0;
    end
    m_ptr     = 0;
    m_ovr     = 1'b0;
    m_td_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input int t);
    logic [N-1:0] fin;
    logic         rdy;
    beat_t        b;
    @(posedge clk);
    #1;
    fin = '0;
    for (int k = 0; k < ntiles; k++)
      for (int i = 0; i < N; i++)
        if (t == t_start[k] + t_dly[k][i]) begin
          fin[i]    = 1'b1;
          pe_val[i] = DW'(t_base[k] + i);
        end
    rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : !(t >= rdy_lo && t <= rdy_hi);
    finish    = fin;
    out_ready = rdy;

    exp_vld = row_full(m_ptr);
    exp_row = m_ptr;
    exp_td  = m_td_pend;
    exp_ovr = m_ovr;
    for (int c = 0; c < SIZE; c++) exp_dat[c*DW +: DW] = m_shadow[m_ptr*SIZE + c];
    chk_en = 1'b1;

    m_td_pend = 1'b0;
    if (exp_vld && rdy) begin
      b.dat  = exp_dat;
      b.row  = RW'(m_ptr);
      b.last = (m_ptr == SIZE - 1);
      exp_q.push_back(b);
      for (int c = 0; c < SIZE; c++) m_mask[m_ptr*SIZE + c] = 1'b0;
      m_td_pend = b.last;
      m_ptr     = (m_ptr + 1) % SIZE;
    end
    for (int i = 0; i < N; i++) begin
      if (fin[i] && !m_prev[i]) begin
        if (!m_mask[i]) begin
          m_mask[i]   = 1'b1;
          m_shadow[i] = pe_val[i];
        end else begin
          m_ovr = 1'b1;
        end
      end
      m_prev[i] = fin[i];
    end
  endtask

  task automatic run_phase(input int ncyc);
    for (int t = 0; t < ncyc; t++) step(t);
  endtask

  task automatic end_phase(input string nm);
    @(negedge clk);
    #1;
    chk({nm, "_drained"}, W'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    chk_en    = 1'b0;
    rst_n     = 1'b0;
    finish    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data",  out_data,      '0);
    chk("rst_out_row",   W'(out_row),   '0);
    chk("rst_out_last",  W'(out_last),  '0);
    chk("rst_tile_done", W'(tile_done), '0);
    chk("rst_overrun",   W'(overrun),   '0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    if (rst_n && chk_en) begin
      chk("out_valid", W'(out_valid), W'(exp_vld));
      chk("tile_done", W'(tile_done), W'(exp_td));
      chk("overrun",   W'(overrun),   W'(exp_ovr));
      chk("out_row",   W'(out_row),   W'(exp_row));
      chk("out_last",  W'(out_last),  W'(exp_vld && exp_row == SIZE - 1));
      if (exp_vld) chk("out_data", out_data, exp_dat);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL beat_unexpected: got row %0d, want no beat", out_row);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", out_data,    b.dat);
          chk("beat_row",  W'(out_row), W'(b.row));
          chk("beat_last", W'(out_last), W'(b.last));
        end
      end
    end
  end

  initial begin
    int st;
    for (int i = 0; i < N; i++) pe_val[i] = '0;
    model_clear();
    ntiles = 0; rdy_lo = 1000; rdy_hi = -1; rdy_rand = 1'b0;
    #2;
    do_reset();

    ntiles = 0; add_wave(0, 0); rdy_lo = 1000; rdy_hi = -1;
    run_phase(24); end_phase("clean");

    ntiles = 0; add_wave(0, 0); rdy_lo = 8; rdy_hi = 20;
    run_phase(34); end_phase("backpressure");

    ntiles = 0; add_wave(0, 0); add_wave(8, 100); rdy_lo = 1000; rdy_hi = -1;
    run_phase(32); end_phase("back2back");

    ntiles = 0; add_wave(0, 0); add_wave(10, 100); rdy_lo = 0; rdy_hi = 30;
    run_phase(50); end_phase("overrun");
    chk("overrun_sticky", W'(overrun), W'(1));
    do_reset();

    ntiles = 0; add_wave(0, 0); rdy_lo = 1000; rdy_hi = -1;
    run_phase(11);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    chk("mid_drain_valid", W'(out_valid), W'(1));
    chk("mid_drain_row",   W'(out_row),   W'(3));
    chk("mid_drain_beats", W'(exp_q.size()), '0);
    do_reset();
    ntiles = 0; add_wave(0, 200);
    run_phase(24); end_phase("after_reset");

    rdy_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ntiles = 0;
      st = 0;
      for (int j = 0; j < 4; j++) begin
        add_rand_tile(st, 300 + k * 256 + j * 64);
        st = st + $urandom_range(4, 20);
      end
      run_phase(150); end_phase("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
